// File: rtl/proc_feeder_pkg.sv
// rtl/proc_feeder_pkg.sv - shared opcodes, error codes and FSM encoding for proc_feeder
package proc_feeder_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_TRUNC   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIN,
        S_ERR
    } state_t;

    function automatic logic [2:0] word_opcode(input logic [15:0] w);
        return w[15:13];
    endfunction

endpackage

// File: rtl/proc_feeder_if.sv
// rtl/proc_feeder_if.sv - Run/Done/DIN handshake between feeder and processor
interface proc_feeder_if;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;

    modport master (output DIN, output Run, input Done);
    modport slave  (input DIN, input Run, output Done);
endinterface

// File: rtl/feeder_progmem.sv
// rtl/feeder_progmem.sv - program memory, sync write, two async read ports
module feeder_progmem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [15:0]       rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [15:0]       rdata1
);

    logic [15:0] mem [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/proc_feeder.sv
// rtl/proc_feeder.sv - instruction sequencer driving the processor Run/Done handshake
module proc_feeder
    import proc_feeder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    proc_feeder_if.master     pif,
    output logic              busy,
    output logic              finished,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   instr_count,
    output logic [ADDR_W-1:0] pc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_n;
    logic [ADDR_W:0]   cnt_n;
    logic [ADDR_W:0]   len_r, len_n;
    logic              is_mvi, is_mvi_n;
    logic [CNT_W-1:0]  tcnt, tcnt_n;
    logic              fin_n, err_n;
    logic [1:0]        code_n;
    logic [15:0]       din, rd0, rd1;
    logic              run;
    logic [2:0]        op;
    logic [ADDR_W:0]   pc_p1_ext, pc_p2_ext, pc_new, len_clamped;

    feeder_progmem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk    (clk),
        .we     (prog_we && !busy),
        .waddr  (prog_addr),
        .wdata  (prog_data),
        .raddr0 (pc),
        .rdata0 (rd0),
        .raddr1 (pc + ADDR_W'(1)),
        .rdata1 (rd1)
    );

    assign op          = word_opcode(rd0);
    assign pc_p1_ext   = {1'b0, pc} + (ADDR_W+1)'(1);
    assign pc_p2_ext   = {1'b0, pc} + (ADDR_W+1)'(2);
    assign pc_new      = is_mvi ? pc_p2_ext : pc_p1_ext;
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign busy        = (state == S_ISSUE) || (state == S_WAIT);
    assign pif.DIN     = din;
    assign pif.Run     = run;

    // Next-state, handshake outputs and status updates.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        cnt_n    = instr_count;
        len_n    = len_r;
        is_mvi_n = is_mvi;
        tcnt_n   = tcnt;
        fin_n    = finished;
        err_n    = err;
        code_n   = err_code;
        din      = 16'h0000;
        run      = 1'b0;
        case (state)
            S_IDLE, S_FIN, S_ERR: begin
                if (start) begin
                    pc_n   = '0;
                    cnt_n  = '0;
                    tcnt_n = '0;
                    err_n  = 1'b0;
                    code_n = ERR_NONE;
                    len_n  = len_clamped;
                    if (prog_len == '0) begin
                        state_n = S_FIN;
                        fin_n   = 1'b1;
                    end else begin
                        state_n = S_ISSUE;
                        fin_n   = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                din = rd0;
                // Bad words are caught before Run so the processor never sees them.
                if (op[2]) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                    code_n  = ERR_ILLEGAL;
                end else if (op == OP_MVI && pc_p1_ext >= len_r) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                    code_n  = ERR_TRUNC;
                end else begin
                    run      = 1'b1;
                    state_n  = S_WAIT;
                    tcnt_n   = '0;
                    is_mvi_n = (op == OP_MVI);
                end
            end
            S_WAIT: begin
                din    = is_mvi ? rd1 : rd0;
                tcnt_n = tcnt + CNT_W'(1);
                if (pif.Done) begin
                    pc_n  = pc_new[ADDR_W-1:0];
                    cnt_n = instr_count + (ADDR_W+1)'(1);
                    if (pc_new >= len_r) begin
                        state_n = S_FIN;
                        fin_n   = 1'b1;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end else if (tcnt == TMO_LAST) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            instr_count <= '0;
            len_r       <= '0;
            is_mvi      <= 1'b0;
            tcnt        <= '0;
            finished    <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_count <= cnt_n;
            len_r       <= len_n;
            is_mvi      <= is_mvi_n;
            tcnt        <= tcnt_n;
            finished    <= fin_n;
            err         <= err_n;
            err_code    <= code_n;
        end
    end

endmodule

// File: tb/tb_proc_feeder.sv
// tb/tb_proc_feeder.sv - randomized self-checking bench for proc_feeder
module tb_proc_feeder;
    import proc_feeder_pkg::*;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 8;
    localparam int STUCK   = 1000;

    logic              clk = 1'b0;
    logic              Reset;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic              busy, finished, err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   instr_count;
    logic [ADDR_W-1:0] pc;

    proc_feeder_if pif ();

    proc_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .start       (start),
        .prog_len    (prog_len),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pif         (pif),
        .busy        (busy),
        .finished    (finished),
        .err         (err),
        .err_code    (err_code),
        .instr_count (instr_count),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shadow of what the program memory should hold, and per-issue processor latency.
    logic [15:0] shadow [DEPTH];
    int          lat_tab [64];

    // Processor model state.
    logic [15:0] R [8];
    logic [15:0] cur, imm;
    int          issue_idx, cd, wcyc, run_pulses;
    bit          active;

    // Reference model results.
    logic [15:0] mr [8];
    int e_fin, e_err, e_code, e_n, e_pc, e_bc, e_runs;

    function automatic void exec_proc(input logic [15:0] w, input logic [15:0] im);
        case (w[15:13])
            3'd0: R[w[12:10]] = R[w[9:7]];
            3'd1: R[w[12:10]] = im;
            3'd2: R[w[12:10]] = R[w[12:10]] + R[w[9:7]];
            3'd3: R[w[12:10]] = R[w[12:10]] - R[w[9:7]];
            default: ;
        endcase
    endfunction

    function automatic void exec_ref(input logic [15:0] w, input logic [15:0] im);
        case (w[15:13])
            3'd0: mr[w[12:10]] = mr[w[9:7]];
            3'd1: mr[w[12:10]] = im;
            3'd2: mr[w[12:10]] = mr[w[12:10]] + mr[w[9:7]];
            3'd3: mr[w[12:10]] = mr[w[12:10]] - mr[w[9:7]];
            default: ;
        endcase
    endfunction

    // Processor: latches the word on Run, the immediate in the first wait cycle,
    // and raises Done for one cycle after its scheduled latency.
    initial begin
        pif.Done = 1'b0;
        forever begin
            @(negedge clk);
            pif.Done = 1'b0;
            if (pif.Run) begin
                cur = pif.DIN;
                cd = lat_tab[issue_idx];
                issue_idx++;
                run_pulses++;
                active = 1'b1;
                wcyc = 0;
            end else if (active) begin
                wcyc++;
                if (wcyc == 1) imm = pif.DIN;
                if (wcyc == cd) begin
                    pif.Done = 1'b1;
                    exec_proc(cur, imm);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic reset_proc();
        for (int i = 0; i < 8; i++) R[i] = 16'h0;
        active = 1'b0;
        issue_idx = 0;
        run_pulses = 0;
    endtask

    // Walks the program word by word using the instruction rules and latencies.
    task automatic ref_run(input int len);
        int L, p, lat;
        logic [15:0] w;
        logic [2:0]  o;
        L = (len > DEPTH) ? DEPTH : len;
        p = 0; e_n = 0; e_bc = 0; e_fin = 0; e_err = 0; e_code = 0; e_runs = 0;
        for (int i = 0; i < 8; i++) mr[i] = 16'h0;
        if (L == 0) begin
            e_fin = 1;
        end else begin
            while (1) begin
                if (p >= L) begin e_fin = 1; break; end
                w = shadow[p % DEPTH];
                o = w[15:13];
                e_bc += 1;
                if (o >= 3'd4) begin e_err = 1; e_code = 2; break; end
                if (o == 3'd1 && p + 1 >= L) begin e_err = 1; e_code = 3; break; end
                lat = lat_tab[e_runs];
                e_runs++;
                if (lat > TIMEOUT) begin
                    e_bc += TIMEOUT;
                    e_err = 1;
                    e_code = 1;
                    if (lat < 100) exec_ref(w, shadow[(p + 1) % DEPTH]);
                    break;
                end
                e_bc += lat;
                exec_ref(w, shadow[(p + 1) % DEPTH]);
                e_n++;
                p += (o == 3'd1) ? 2 : 1;
            end
        end
        e_pc = p % DEPTH;
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        prog_we = 1'b1;
        prog_addr = a[ADDR_W-1:0];
        prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic run_prog(input int len, input string name);
        int bc, cyc;
        ref_run(len);
        reset_proc();
        prog_len = len[ADDR_W:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        cyc = 0;
        while (cyc < 3000) begin
            if (busy) bc++;
            else if (finished || err) break;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) check({name, ".hang"}, 32'd1, 32'd0);
        repeat (TIMEOUT + 6) @(negedge clk);
        check({name, ".finished"}, finished, e_fin);
        check({name, ".err"}, err, e_err);
        check({name, ".err_code"}, err_code, e_code);
        check({name, ".instr_count"}, instr_count, e_n);
        check({name, ".pc"}, pc, e_pc);
        check({name, ".busy_cycles"}, bc, e_bc);
        check({name, ".run_pulses"}, run_pulses, e_runs);
        for (int i = 0; i < 8; i++) check($sformatf("%s.R%0d", name, i), R[i], mr[i]);
    endtask

    task automatic set_lat3(input int a, input int b, input int c);
        for (int i = 0; i < 64; i++) lat_tab[i] = 1;
        lat_tab[0] = a; lat_tab[1] = b; lat_tab[2] = c;
    endtask

    initial begin
        int k, len, r;
        logic [2:0] o;
        Reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        reset_proc();
        for (int i = 0; i < 64; i++) lat_tab[i] = 1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 16'h0;
        repeat (3) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.finished", finished, 0);
        check("rst.err", err, 0);
        check("rst.err_code", err_code, 0);
        check("rst.instr_count", instr_count, 0);
        check("rst.pc", pc, 0);
        check("rst.Run", pif.Run, 0);
        check("rst.DIN", pif.DIN, 0);
        Reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'h0);

        // mvi R0,5 ; mv R1,R0 ; add R0,R1
        load_word(0, 16'h2000); load_word(1, 16'h0005); load_word(2, 16'h0400); load_word(3, 16'h4080);
        set_lat3(1, 1, 3);
        run_prog(4, "basic");
        check("basic.R0_const", R[0], 16'd10);
        check("basic.R1_const", R[1], 16'd5);
        check("basic.pc_const", pc, 4);

        // mvi R0,9 ; mvi R1,3 ; sub R0,R1
        load_word(0, 16'h2000); load_word(1, 16'h0009); load_word(2, 16'h2400);
        load_word(3, 16'h0003); load_word(4, 16'h6080);
        set_lat3(1, 1, 3);
        run_prog(5, "sub");
        check("sub.R0_const", R[0], 16'h0006);
        check("sub.busy_const", e_bc, 8);

        load_word(0, 16'h0400);
        set_lat3(STUCK, 1, 1);
        run_prog(1, "timeout");

        load_word(0, 16'h8000);
        run_prog(2, "illegal");

        load_word(0, 16'h2000);
        run_prog(1, "trunc");

        run_prog(0, "empty");

        // Reset in the wait of the 2nd instruction, with a write attempted while busy.
        load_word(0, 16'h2000); load_word(1, 16'h0005); load_word(2, 16'h0400); load_word(3, 16'h4080);
        set_lat3(1, 3, 3);
        reset_proc();
        prog_len = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        for (int c = 0; c < 50 && k < 2; c++) begin
            if (pif.Run) k++;
            if (k < 2) @(negedge clk);
        end
        check("rst_mid.saw_issue2", k, 2);
        prog_we = 1'b1; prog_addr = '0; prog_data = 16'hFFFF;
        @(negedge clk);
        prog_we = 1'b0;
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check("rst_mid.busy", busy, 0);
        check("rst_mid.Run", pif.Run, 0);
        check("rst_mid.pc", pc, 0);
        repeat (6) @(negedge clk);
        set_lat3(1, 1, 3);
        run_prog(4, "rerun");
        check("rerun.R0_const", R[0], 16'd10);

        // Randomized programs, lengths and latencies.
        for (int it = 0; it < 25; it++) begin
            k = 0;
            while (k < DEPTH) begin
                r = $urandom_range(0, 15);
                o = (r == 0) ? 3'($urandom_range(4, 7)) : 3'(r % 4);
                load_word(k, {o, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 7'd0});
                k++;
                if (o == OP_MVI && k < DEPTH) begin
                    load_word(k, 16'($urandom));
                    k++;
                end
            end
            for (int i = 0; i < 64; i++)
                lat_tab[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT + 3 : $urandom_range(1, TIMEOUT);
            len = $urandom_range(0, 20);
            run_prog(len, $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
